// File: rtl/conf_loader.sv
`default_nettype none
// ============================================================================
//  Module      : conf_loader
//  Description : Streams configuration words from a word-addressed memory
//                into N_RC parallel RC configuration register files.
//                The memory image is PC-major (word k = pc*N_RC + rc), and
//                there is one read outstanding at a time:
//                REQ -> WAIT -> WRITE per word.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_i        clock, synchronous active-high reset
//    start_i             load request (sampled in IDLE only)
//    base_addr_i         byte address of word 0 (bits [1:0] forced to 0)
//    num_instr_i         PC slots to load per RC (clamped to RCS_NUM_CREG)
//    abort_i             finish the in-flight word, then stop
//    mem_req_o/addr_o    read request and word-aligned address
//    mem_gnt_i           request accepted
//    mem_rvalid_i/rdata  read response
//    instr_o, pc_o       data and slot for the conf register file
//    we_o, ce_o          one-hot RC write enable and conf-file clock enable
//    busy_o              high outside IDLE
//    done_o, aborted_o   one-cycle completion pulses
// ============================================================================
module conf_loader #(
    parameter  int INSTR_WIDTH  = 32,
    parameter  int RCS_NUM_CREG = 32,
    parameter  int N_RC         = 4,
    localparam int PCW          = $clog2(RCS_NUM_CREG),
    localparam int CW           = PCW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [31:0]            base_addr_i,
    input  logic [CW-1:0]          num_instr_i,
    input  logic                   abort_i,
    output logic                   mem_req_o,
    output logic [31:0]            mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [PCW-1:0]         pc_o,
    output logic [N_RC-1:0]        we_o,
    output logic                   ce_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o
);

    localparam int RCW = (N_RC > 1) ? $clog2(N_RC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_n;
    logic [PCW-1:0]  r_pc;
    logic [RCW-1:0]  r_rc;
    logic            r_abort;

    logic [CW-1:0]   w_n;
    logic            w_last;
    logic [N_RC-1:0] w_we_onehot;

    // Requests beyond the register file depth are clamped to the full depth.
    assign w_n = (num_instr_i > CW'(RCS_NUM_CREG)) ? CW'(RCS_NUM_CREG) : num_instr_i;

    // Last word of the load: final PC slot of the final RC.
    assign w_last = ({1'b0, r_pc} == (r_n - CW'(1))) && (r_rc == RCW'(N_RC - 1));

    always_comb begin
        w_we_onehot = '0;
        for (int i = 0; i < N_RC; i++) begin
            w_we_onehot[i] = (r_rc == RCW'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_pc       <= '0;
            r_rc       <= '0;
            r_abort    <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            instr_o    <= '0;
            pc_o       <= '0;
            we_o       <= '0;
            ce_o       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            aborted_o  <= 1'b0;
        end else begin
            // Pulses and write strobes default low every cycle.
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
            we_o      <= '0;
            ce_o      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_n     <= w_n;
                        r_pc    <= '0;
                        r_rc    <= '0;
                        r_abort <= 1'b0;
                        if (w_n == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            busy_o     <= 1'b1;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= base_addr_i & ~32'h3;
                        end
                    end
                end

                S_REQ: begin
                    if (abort_i) begin
                        r_abort <= 1'b1;
                    end
                    // Request and address stay put until the grant arrives.
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (abort_i) begin
                        r_abort <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        instr_o <= mem_rdata_i;
                        pc_o    <= r_pc;
                        we_o    <= w_we_onehot;
                        ce_o    <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // The last word always completes normally, even when an
                    // abort is pending.
                    if (w_last) begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        r_abort <= 1'b0;
                    end else if (r_abort || abort_i) begin
                        r_state   <= S_IDLE;
                        busy_o    <= 1'b0;
                        aborted_o <= 1'b1;
                        r_abort   <= 1'b0;
                    end else begin
                        if (r_rc == RCW'(N_RC - 1)) begin
                            r_rc <= '0;
                            r_pc <= r_pc + PCW'(1);
                        end else begin
                            r_rc <= r_rc + RCW'(1);
                        end
                        // PC-major layout makes the next word simply the next
                        // address; the add wraps modulo 2^32.
                        r_state    <= S_REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= mem_addr_o + 32'd4;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conf_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conf_loader
//  Description : Self-checking bench for conf_loader with a configurable
//                memory responder and an arithmetic reference of each load.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conf_loader;

    localparam int IW  = 32;
    localparam int NC  = 32;
    localparam int NR  = 4;
    localparam int PCW = 5;
    localparam int CW  = 6;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [CW-1:0] num_instr_i = '0;
    logic          abort_i = 1'b0;
    logic          mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [IW-1:0] mem_rdata_i;
    logic [IW-1:0] instr_o;
    logic [PCW-1:0] pc_o;
    logic [NR-1:0] we_o;
    logic          ce_o;
    logic          busy_o;
    logic          done_o;
    logic          aborted_o;

    conf_loader #(.INSTR_WIDTH(IW), .RCS_NUM_CREG(NC), .N_RC(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_instr_i(num_instr_i), .abort_i(abort_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .instr_o(instr_o), .pc_o(pc_o), .we_o(we_o), .ce_o(ce_o),
        .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory responder ----------------
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          req_cnt   = 0;
    logic        pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = '0;

    assign mem_gnt_i    = mem_req_o && (req_cnt >= gnt_delay);
    assign mem_rvalid_i = pend && (pend_cnt == 0);
    assign mem_rdata_i  = data_of(pend_addr);

    always @(posedge clk_i) begin
        if (mem_req_o && !mem_gnt_i) req_cnt <= req_cnt + 1;
        else                         req_cnt <= 0;
        if (mem_req_o && mem_gnt_i) begin
            pend      <= 1'b1;
            pend_cnt  <= rv_delay;
            pend_addr <= mem_addr_o;
        end else if (pend) begin
            if (pend_cnt == 0) pend <= 1'b0;
            else               pend_cnt <= pend_cnt - 1;
        end
    end

    // ---------------- scoring ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [NR-1:0]  we;
        logic [IW-1:0]  instr;
    } wr_t;

    // observed
    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    int n_done, n_ab, fin_cyc, unstable, ce_err, busy_err;
    bit fin_found;

    // reference
    logic [31:0] m_rd[$];
    wr_t         m_wr[$];
    int m_done, m_ab, m_lat;
    bit m_busy;

    task automatic build_model(input logic [31:0] base, input int num, input int gd,
                               input int rd, input int abw);
        int n, tot, words;
        logic [31:0] a;
        n     = (num > NC) ? NC : num;
        tot   = n * NR;
        words = (abw >= 0 && abw < tot) ? abw + 1 : tot;
        m_ab   = (words < tot) ? 1 : 0;
        m_done = 1 - m_ab;
        m_lat  = words * (3 + gd + rd);
        m_busy = (words > 0);
        m_rd.delete();
        m_wr.delete();
        for (int k = 0; k < words; k++) begin
            a = (base & ~32'h3) + 32'(4 * k);
            m_rd.push_back(a);
            m_wr.push_back({PCW'(k / NR), NR'(1 << (k % NR)), data_of(a)});
        end
    endtask

    task automatic run_load(input logic [31:0] base, input int num, input int gd,
                            input int rd, input int abw, input bit idle_abort,
                            input bit restart);
        int phase, post;
        bit fin, prev_wait;
        logic [31:0] prev_addr;
        rd_q.delete(); wr_q.delete();
        n_done = 0; n_ab = 0; fin_cyc = 0; unstable = 0; ce_err = 0; busy_err = 0;
        fin = 0; phase = 0; post = 0; prev_wait = 0; prev_addr = '0;
        @(negedge clk_i);
        gnt_delay = gd;
        rv_delay  = rd;
        if (idle_abort) begin
            abort_i = 1'b1;
            @(negedge clk_i);
            abort_i = 1'b0;
        end
        base_addr_i = base;
        num_instr_i = CW'(num);
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        base_addr_i = $urandom;
        num_instr_i = CW'($urandom);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (prev_wait && (!mem_req_o || mem_addr_o != prev_addr)) unstable++;
            prev_wait = mem_req_o && !mem_gnt_i;
            prev_addr = mem_addr_o;
            if (mem_req_o && mem_gnt_i) rd_q.push_back(mem_addr_o);
            if (we_o != '0) wr_q.push_back({pc_o, we_o, instr_o});
            if (ce_o != (we_o != '0)) ce_err++;
            if ($countones(we_o) > 1) ce_err++;
            if (done_o) n_done++;
            if (aborted_o) n_ab++;
            if (!fin && (done_o || aborted_o)) begin
                fin = 1;
                fin_cyc = cyc;
            end
            if (busy_o != (fin ? 1'b0 : m_busy)) busy_err++;
            if (fin) begin
                post++;
                if (post > 4) break;
            end
            if (phase == 1) begin
                abort_i = 1'b1;
                phase = 2;
            end else if (phase == 2) begin
                abort_i = 1'b0;
                phase = 3;
            end
            if (phase == 0 && abw >= 0 && mem_req_o && mem_gnt_i && rd_q.size() == abw + 1)
                phase = 1;
            if (restart && cyc == 4) begin
                start_i     = 1'b1;
                base_addr_i = 32'h8000;
                num_instr_i = CW'(3);
            end else if (restart && cyc == 5) begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
        end
        abort_i   = 1'b0;
        start_i   = 1'b0;
        fin_found = fin;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".finished"}, fin_found, 1);
        chk({tag, ".reads"}, rd_q.size(), m_rd.size());
        for (int i = 0; i < rd_q.size() && i < m_rd.size(); i++)
            chk($sformatf("%s.addr%0d", tag, i), rd_q[i], m_rd[i]);
        chk({tag, ".writes"}, wr_q.size(), m_wr.size());
        for (int i = 0; i < wr_q.size() && i < m_wr.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), wr_q[i], m_wr[i]);
        chk({tag, ".done"}, n_done, m_done);
        chk({tag, ".aborted"}, n_ab, m_ab);
        chk({tag, ".latency"}, fin_found ? fin_cyc - 1 : -1, m_lat);
        chk({tag, ".addr_stable"}, unstable, 0);
        chk({tag, ".we_ce"}, ce_err, 0);
        chk({tag, ".busy"}, busy_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".mem_req"}, mem_req_o, 0);
        chk({tag, ".mem_addr"}, mem_addr_o, 0);
        chk({tag, ".we"}, we_o, 0);
        chk({tag, ".ce"}, ce_o, 0);
        chk({tag, ".busy"}, busy_o, 0);
        chk({tag, ".done"}, done_o, 0);
        chk({tag, ".aborted"}, aborted_o, 0);
        chk({tag, ".instr"}, instr_o, 0);
        chk({tag, ".pc"}, pc_o, 0);
    endtask

    typedef struct {
        logic [31:0] base;
        int          num, gd, rd, abw;
        bit          idle_ab, restart;
        int          e_reads;
        int          e_done, e_ab;
        int          e_pc;
        logic [3:0]  e_we;
        int          e_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0000_1000,  2, 0, 0, -1, 1'b0, 1'b0,   8, 1, 0,  1, 4'b1000,  24};
        vecs[1] = '{32'h0000_1000,  0, 0, 0, -1, 1'b0, 1'b0,   0, 1, 0,  0, 4'b0000,   0};
        vecs[2] = '{32'h0000_0000, 40, 0, 0, -1, 1'b0, 1'b0, 128, 1, 0, 31, 4'b1000, 384};
        vecs[3] = '{32'h0000_2003,  1, 3, 0, -1, 1'b0, 1'b0,   4, 1, 0,  0, 4'b1000,  24};
        vecs[4] = '{32'h0000_1000,  2, 0, 0,  5, 1'b0, 1'b0,   6, 0, 1,  1, 4'b0010,  18};
        vecs[5] = '{32'h0000_1000,  2, 0, 0,  7, 1'b0, 1'b0,   8, 1, 0,  1, 4'b1000,  24};
        vecs[6] = '{32'hFFFF_FFF8,  1, 0, 1, -1, 1'b0, 1'b0,   4, 1, 0,  0, 4'b1000,  16};
        vecs[7] = '{32'h0000_4000, 32, 1, 1, -1, 1'b1, 1'b1, 128, 1, 0, 31, 4'b1000, 640};
        vecs[8] = '{32'h0000_0100,  3, 2, 2,  0, 1'b0, 1'b0,   1, 0, 1,  0, 4'b0001,   7};

        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        rst_i = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            build_model(vecs[i].base, vecs[i].num, vecs[i].gd, vecs[i].rd, vecs[i].abw);
            run_load(vecs[i].base, vecs[i].num, vecs[i].gd, vecs[i].rd, vecs[i].abw,
                     vecs[i].idle_ab, vecs[i].restart);
            compare_model(tag);
            chk({tag, ".t_reads"}, rd_q.size(), vecs[i].e_reads);
            chk({tag, ".t_done"}, n_done, vecs[i].e_done);
            chk({tag, ".t_aborted"}, n_ab, vecs[i].e_ab);
            chk({tag, ".t_latency"}, fin_found ? fin_cyc - 1 : -1, vecs[i].e_lat);
            if (vecs[i].e_reads > 0) begin
                chk({tag, ".t_first_addr"}, (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_DEAD,
                    vecs[i].base & ~32'h3);
                chk({tag, ".t_last_pc"}, (wr_q.size() > 0) ? wr_q[$].pc : 99, vecs[i].e_pc);
                chk({tag, ".t_last_we"}, (wr_q.size() > 0) ? wr_q[$].we : 4'hF, vecs[i].e_we);
            end
        end

        // ---- reset while waiting for read data, then a late rvalid ----
        begin
            int nreq, nwe;
            bit seen;
            @(negedge clk_i);
            gnt_delay   = 0;
            rv_delay    = 3;
            base_addr_i = 32'h3000;
            num_instr_i = CW'(2);
            start_i     = 1'b1;
            @(negedge clk_i);
            start_i = 1'b0;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (mem_req_o && mem_gnt_i) begin
                    seen = 1;
                    break;
                end
                @(negedge clk_i);
            end
            chk("rst.grant_seen", seen, 1);
            @(negedge clk_i);
            chk("rst.in_wait_busy", busy_o, 1);
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
            nreq = 0;
            nwe  = 0;
            for (int c = 0; c < 8; c++) begin
                if (mem_req_o) nreq++;
                if (we_o != '0) nwe++;
                @(negedge clk_i);
            end
            chk("rst.no_req", nreq, 0);
            chk("rst.no_we", nwe, 0);
            check_reset_vals("rst");
        end

        // ---- randomized loads against the reference ----
        for (int r = 0; r < 20; r++) begin
            logic [31:0] b;
            int num, gd, rd, abw, n;
            b   = $urandom;
            num = $urandom_range(0, 40);
            gd  = $urandom_range(0, 2);
            rd  = $urandom_range(0, 2);
            n   = (num > NC) ? NC : num;
            if (n == 0 || $urandom_range(0, 2) == 0) abw = -1;
            else abw = $urandom_range(0, n * NR);
            build_model(b, num, gd, rd, abw);
            run_load(b, num, gd, rd, abw, 1'b0, 1'b0);
            compare_model($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
